// File: rtl/mips_muldiv_if.sv
// Core-side handshake between the execute stage and the HI/LO multiply/divide unit.
// The core drives requests and MTHI/MTLO data; the unit returns status and HI/LO.
interface mips_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             mthi;
    logic             mtlo;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, op_a, op_b, mthi, mtlo, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, op_a, op_b, mthi, mtlo, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mips_muldiv.sv
// Iterative MIPS multiply/divide unit owning HI/LO: one shared WIDTH-step datapath
// runs shift-add multiply or restoring divide on operand magnitudes, then fixes signs.
module mips_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clk_enable,
    mips_muldiv_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIX
    } state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q;
    logic               is_div_q, div0_q, sign_a_q, sign_b_q;
    logic [2*WIDTH-1:0] acc_q;   // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [WIDTH-1:0]   opd_q;   // multiplicand or divisor magnitude
    logic [WIDTH-1:0]   hi_q, lo_q;
    logic               done_q;

    // Operand capture: magnitudes for signed ops, raw values for unsigned ops.
    logic             op_signed, sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;

    always_comb begin
        op_signed = ~bus.op[0];
        sa        = op_signed & bus.op_a[WIDTH-1];
        sb        = op_signed & bus.op_b[WIDTH-1];
        mag_a     = sa ? -bus.op_a : bus.op_a;
        mag_b     = sb ? -bus.op_b : bus.op_b;
    end

    // One iteration of either algorithm.
    logic [WIDTH:0]     shifted, mul_sum;
    logic               div_ok;
    logic [WIDTH-1:0]   div_sub, rem_next;
    logic [2*WIDTH-1:0] step_acc;

    always_comb begin
        shifted  = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ok   = shifted >= {1'b0, opd_q};
        // The true difference fits in WIDTH bits whenever it is kept, so truncation is exact.
        div_sub  = shifted[WIDTH-1:0] - opd_q;
        rem_next = div_ok ? div_sub : shifted[WIDTH-1:0];
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                 + {1'b0, (acc_q[0] ? opd_q : {WIDTH{1'b0}})};
        step_acc = is_div_q ? {rem_next, acc_q[WIDTH-2:0], div_ok}
                            : {mul_sum, acc_q[WIDTH-1:1]};
    end

    // Sign fixup. A zero divisor leaves remainder = |a|, so the remainder rule
    // restores the original op_a; only the all-ones quotient skips the fixup.
    logic               neg_res;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   rem_fix, quo_fix, res_hi, res_lo;

    always_comb begin
        neg_res  = sign_a_q ^ sign_b_q;
        prod_fix = neg_res ? -acc_q : acc_q;
        rem_fix  = sign_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        quo_fix  = (neg_res && !div0_q) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        res_hi   = is_div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
        res_lo   = is_div_q ? quo_fix : prod_fix[WIDTH-1:0];
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = RUN;
            RUN:     if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset)           state_q <= IDLE;
        else if (clk_enable) state_q <= state_d;
    end

    // NOTE: the datapath registers are cleared with everything else; they are plain flops, not a memory array.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            sign_a_q <= 1'b0;
            sign_b_q <= 1'b0;
            acc_q    <= '0;
            opd_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else if (clk_enable) begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.mthi) hi_q <= bus.wdata;
                    if (bus.mtlo) lo_q <= bus.wdata;
                    if (bus.start) begin
                        cnt_q    <= '0;
                        is_div_q <= bus.op[1];
                        div0_q   <= (bus.op_b == '0);
                        sign_a_q <= sa;
                        sign_b_q <= sb;
                        acc_q    <= {{WIDTH{1'b0}}, (bus.op[1] ? mag_a : mag_b)};
                        opd_q    <= bus.op[1] ? mag_b : mag_a;
                    end
                end
                RUN: begin
                    acc_q <= step_acc;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIX: begin
                    hi_q   <= res_hi;
                    lo_q   <= res_lo;
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (state_q != IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Randomized self-checking bench for mips_muldiv against a plain-arithmetic model
// of MIPS MULT/MULTU/DIV/DIVU, plus the directed hazard and reset scenarios.
module tb_mips_muldiv;

    localparam int W = 32;

    logic clk = 1'b0;
    logic reset;
    logic clk_enable;
    int   n_checks = 0;
    int   n_fail   = 0;

    mips_muldiv_if #(.WIDTH(W)) bus ();

    mips_muldiv #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clk_enable (clk_enable),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference result {hi, lo} from the architectural definition of each op.
    function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        int     q, r;
        case (op)
            2'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            2'd1: return {32'd0, a} * {32'd0, b};
            2'd2: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input string tag);
        logic [63:0] exp, hilo0;
        int          edges;
        bit          seen;
        exp   = model(op, a, b);
        hilo0 = {bus.hi, bus.lo};
        bus.op    = op;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.op    = 2'($urandom);
        bus.op_a  = $urandom;
        bus.op_b  = $urandom;
        check({tag, "_busy"}, 64'(bus.busy), 64'd1);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 100) begin
            tick();
            edges++;
            if (bus.done) seen = 1;
            else if (edges == 16) check({tag, "_hold"}, {bus.hi, bus.lo}, hilo0);
        end
        check({tag, "_latency"}, 64'(edges), 64'd33);
        check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
        check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
        tick();
        check({tag, "_done_pulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        int          edges, pulses;
        bit          seen;
        logic [31:0] a, b;
        logic [1:0]  op;

        reset      = 1'b1;
        clk_enable = 1'b1;
        bus.start  = 1'b0;
        bus.op     = 2'd0;
        bus.op_a   = '0;
        bus.op_b   = '0;
        bus.mthi   = 1'b0;
        bus.mtlo   = 1'b0;
        bus.wdata  = '0;
        tick();
        tick();
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_hilo", {bus.hi, bus.lo}, 64'd0);
            check("idle_flags", 64'({bus.busy, bus.done}), 64'd0);
        end

        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
        check("multu_max_exact", {bus.hi, bus.lo}, 64'hFFFF_FFFE_0000_0001);
        run_op(2'd0, 32'hFFFF_FFFD, 32'd7, "mult_neg");
        check("mult_neg_exact", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd2, "div_neg");
        check("div_neg_exact", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
        check("div_ovf_exact", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op(2'd3, 32'd7, 32'd0, "divu_zero");
        check("divu_zero_exact", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
        run_op(2'd2, 32'hFFFF_FFF9, 32'd0, "div_zero_neg");

        // Ignored start/mthi while busy, plus a 4-edge clock-enable gap mid-RUN.
        bus.op    = 2'd1;
        bus.op_a  = 32'd5;
        bus.op_b  = 32'd6;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        edges = 0;
        seen  = 0;
        while (!seen && edges < 100) begin
            if (edges == 9) begin
                bus.start = 1'b1;
                bus.op    = 2'd3;
                bus.op_a  = 32'd9;
                bus.op_b  = 32'd3;
                bus.mthi  = 1'b1;
                bus.wdata = 32'hDEAD;
            end
            if (edges == 10) begin
                bus.start = 1'b0;
                bus.mthi  = 1'b0;
            end
            if (edges == 12) clk_enable = 1'b0;
            if (edges == 16) clk_enable = 1'b1;
            tick();
            edges++;
            if (bus.done) seen = 1;
        end
        check("hazard_latency", 64'(edges), 64'd37);
        check("hazard_hilo", {bus.hi, bus.lo}, 64'd30);
        tick();
        bus.mtlo  = 1'b1;
        bus.wdata = 32'h1234;
        tick();
        bus.mtlo = 1'b0;
        check("mtlo_idle", {bus.hi, bus.lo}, 64'h0000_0000_0000_1234);
        check("mtlo_no_done", 64'(bus.done), 64'd0);

        // Reset in the middle of a multiply.
        bus.op    = 2'd0;
        bus.op_a  = 32'd3;
        bus.op_b  = 32'd4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (i == 10) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        check("rst_mid_busy", 64'(bus.busy), 64'd0);
        check("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (bus.done) pulses++;
        end
        check("rst_mid_no_done", 64'(pulses), 64'd0);
        run_op(2'd1, 32'd2, 32'd3, "after_rst");

        // Mt write and start in the same IDLE cycle: result overwrites HI/LO.
        bus.mthi  = 1'b1;
        bus.mtlo  = 1'b1;
        bus.wdata = 32'hCAFE;
        bus.op    = 2'd3;
        bus.op_a  = 32'd100;
        bus.op_b  = 32'd7;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.mthi  = 1'b0;
        bus.mtlo  = 1'b0;
        check("mt_start_applied", {bus.hi, bus.lo}, 64'h0000_CAFE_0000_CAFE);
        edges = 0;
        seen  = 0;
        while (!seen && edges < 100) begin
            tick();
            edges++;
            if (bus.done) seen = 1;
        end
        check("mt_start_result", {bus.hi, bus.lo}, {32'd2, 32'd14});

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            case ($urandom_range(0, 5))
                0:       a = 32'h8000_0000;
                1:       a = 32'hFFFF_FFFF;
                2:       a = $urandom_range(0, 20);
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 9);
                3:       b = 32'h8000_0000;
                default: b = $urandom;
            endcase
            run_op(op, a, b, $sformatf("rand%0d_op%0d", n, op));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_muldiv.md
Name: mips_muldiv

Overview:
- Iterative multiply/divide unit that owns the HI/LO registers for the MIPS core.
- Sits beside the ALU on the execute path. The core issues MULT/MULTU/DIV/DIVU with the two register-file operands. It stalls on busy and reads HI/LO for MFHI/MFLO.
- MTHI/MTLO write HI/LO directly.
- One shared 32-step datapath serves both multiply (shift-add) and divide (restoring).

Parameters:
- WIDTH, 32, operand width. Also sets the iteration count; HI/LO are each WIDTH bits.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- clk_enable  input  1  when low, every register holds its value.
- start  input  1  request a new operation; sampled only in IDLE.
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- op_a  input  WIDTH  rs operand (multiplicand or dividend).
- op_b  input  WIDTH  rt operand (multiplier or divisor).
- mthi  input  1  write wdata to HI.
- mtlo  input  1  write wdata to LO.
- wdata  input  WIDTH  MTHI/MTLO data.
- busy  output  1  operation in progress; core must stall HI/LO consumers.
- done  output  1  one-cycle pulse: HI/LO have just been updated by a mul/div.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Clock and reset:
  - One clock: clk. Reset is synchronous and active-high on reset.
  - Reset has priority over clk_enable.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, iteration counter=0.
- clk_enable=0: state, counter, datapath, hi, lo, busy and done all hold. Latency is counted in enabled edges only.
- States: IDLE, RUN, FIX.
- IDLE, start=1 at an enabled edge E0:
  - latch op, |op_a|, |op_b| (magnitudes for signed ops, raw values for unsigned ops) and both sign bits;
  - go to RUN with counter=0; busy=1 from the cycle after E0.
- RUN: one iteration per enabled edge.
  - Multiply: shift-add into a 2*WIDTH accumulator.
  - Divide: restoring shift-subtract, quotient and remainder registers.
  - After WIDTH iterations (edges E1..E32), go to FIX.
- FIX (edge E33):
  - Signed multiply: negate the 64-bit product if sign_a^sign_b.
  - Signed divide: negate the quotient if sign_a^sign_b; negate the remainder if sign_a.
  - Write hi = product[63:32] or remainder; lo = product[31:0] or quotient.
  - Go to IDLE. Registered done=1 and busy=0 in the cycle after E33; done clears at the next enabled edge.
- Total: start-to-done = 33 enabled edges. done and busy are never both 1.
- Divide by zero (op_b=0, DIV or DIVU):
  - same 33-edge latency;
  - lo=32'hFFFFFFFF, hi=op_a (the original, unsigned view); no sign fixup.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000 (wraps), hi=0. No trap.
- start while busy: ignored, no queueing.
- mthi/mtlo:
  - In IDLE, the write takes effect at the edge; HI and LO may be written the same cycle.
  - While busy (RUN or FIX), ignored.
  - In IDLE with start=1 in the same cycle, the mt write is applied and the operation is accepted; completion overwrites HI/LO.
- HI/LO hold their previous values during RUN; they change only at FIX, mthi/mtlo, or reset.
- Reset mid-operation: immediate return to IDLE, hi=lo=0, no done pulse.
- Operands are captured at start; op_a, op_b and op may change freely afterwards.

Test Plan:
- Reset, then idle 5 cycles -> hi=0, lo=0, busy=0, done=0 throughout.
- MULTU op_a=0xFFFFFFFF op_b=0xFFFFFFFF, start at E0 -> busy=1 after E0; done=1 exactly in the cycle after E33; hi=0xFFFFFFFE, lo=0x00000001.
- MULT (-3)*(7) -> hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIV (-7)/(2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
- Hazard sequence:
  - MULTU 5*6; at edge E10 pulse start (DIVU 9/3) with mthi=1, wdata=0xDEAD -> both ignored.
  - Drop clk_enable for 4 cycles mid-RUN -> done arrives 4 cycles later; hi=0, lo=30.
  - Next, in IDLE, mtlo=1 with wdata=0x1234 -> lo=0x1234 on the next cycle, done stays 0.
- MULT 3*4; assert reset at edge E10 for 1 cycle -> busy=0, hi=lo=0, no done pulse.
  - A subsequent MULTU 2*3 completes normally: lo=6, hi=0.
